// File: rtl/key_evt_pkg.sv
// Shared constants and types for the key event arbiter: default sizing and
// the symbolic indices of the front-panel keys.
package key_evt_pkg;

  localparam int N_KEYS_DEFAULT     = 5;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int KEY_IDX_W          = $clog2(N_KEYS_DEFAULT);

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  localparam key_idx_t KEY_CONFIRM = key_idx_t'(0);
  localparam key_idx_t KEY_BACK    = key_idx_t'(1);
  localparam key_idx_t KEY_UP      = key_idx_t'(2);
  localparam key_idx_t KEY_DOWN    = key_idx_t'(3);
  localparam key_idx_t KEY_MODE    = key_idx_t'(4);

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO for key events; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int WIDTH = KEY_IDX_W,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Merges debounced key press pulses into an ordered event stream using a
// round-robin grant into a small FIFO. Optional KEY_EVT_DROP_CNT_EN adds a
// saturating count of cycles in which presses merged into pending ones.
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int N_KEYS     = N_KEYS_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int IDX_W     = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDX_W-1:0]  evt_code,
  output logic [N_KEYS-1:0] pending,
  output logic              fifo_full
`ifdef KEY_EVT_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_found;
  logic              grant_vld;
  logic [N_KEYS-1:0] grant_mask;
  logic              push_ok;
  logic              fifo_empty;
  int                cand;

  assign evt_valid = !fifo_empty;
  assign pending   = pending_q;

  // A pop in this cycle frees a slot, so a full FIFO can still take a push.
  assign push_ok   = !fifo_full || (evt_valid && evt_ready);
  assign grant_vld = push_ok && grant_found;

  // Round-robin search starting just after the most recent grant.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int off = 1; off <= N_KEYS; off++) begin
      cand = (int'(last_grant_q) + off) % N_KEYS;
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    grant_mask   = grant_vld ? (N_KEYS'(1) << grant_idx) : '0;
    // A new pulse on the granted key wins over the clear: the repeat press queues later.
    pending_d    = (pending_q & ~grant_mask) | key_pulse;
    last_grant_d = grant_vld ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      last_grant_q <= IDX_W'(N_KEYS - 1);
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef KEY_EVT_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       merge_hit;

  always_comb begin
    merge_hit  = |(key_pulse & pending_q & ~grant_mask);
    drop_cnt_d = (merge_hit && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  key_evt_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant_vld),
    .pop     (evt_ready),
    .wr_data (grant_idx),
    .rd_data (evt_code),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Collects one-cycle press pulses from several per-button debouncers and converts them into a single ordered stream of key-index events.
- A round-robin arbiter moves pending presses into a small FIFO. The FIFO is drained by the consumer (menu/mode FSM) over a valid/ready handshake.
- Sits between the button debouncer bank and the top-level control FSM, so simultaneous or rapid presses are never lost or reordered unfairly.

Parameters:
- N_KEYS, 5, number of debounced key inputs (2..16).
- FIFO_DEPTH, 4, event FIFO entries (power of two, 2..16).
- IDX_W, $clog2(N_KEYS), localparam, width of the key index.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- key_pulse  in  N_KEYS  one-cycle press pulses, bit i = key i.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_code  out  IDX_W  key index at the FIFO head; 0 when empty.
- pending  out  N_KEYS  per-key pending flags (presses not yet queued).
- fifo_full  out  1  FIFO count == FIFO_DEPTH.

Behaviour:
- Reset (async, rst=1):
  - pending=0; FIFO empty (count=0, rd/wr pointers 0).
  - evt_valid=0, evt_code=0, fifo_full=0.
  - last_grant=N_KEYS-1, so key 0 has first priority.
- Pending set: pending[i] is set at the edge where key_pulse[i]=1.
  - A pulse on an already-pending key merges: still one pending event, no error.
- Push permission: push_ok = (count < FIFO_DEPTH) || (evt_valid && evt_ready). A simultaneous pop frees a slot in the same cycle.
- Grant:
  - Each cycle, if push_ok and pending != 0, grant exactly one key, the first pending index searching (last_grant+1) mod N_KEYS upward with wrap.
  - The granted index is written to the FIFO and pending[g] is cleared; last_grant <= g.
  - At most one push per cycle.
- Grant vs. new pulse: if key_pulse[g]=1 in the grant cycle, pending[g] stays set (set wins over clear). The second press is queued later.
- FIFO full: no grant; pending flags hold; arbitration resumes the cycle space exists.
- Pop: when evt_valid && evt_ready, the head advances. evt_ready while empty is ignored.
- Latency, uncontended: pulse sampled at edge k -> pending at k -> pushed at edge k+1 -> evt_valid=1 after edge k+1, i.e. 2 cycles pulse-to-valid.
- Outputs are registered or derived from registered state only. evt_code is the combinational read of the head entry. No combinational path from evt_ready to evt_valid.
- Pointer arithmetic: pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-operation discards pending and queued events immediately; no partial event is emitted afterwards.

Optional Feature:
- Macro: KEY_EVT_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [7:0], reset 0.
  - Increments (saturating at 255) on every cycle in which at least one key_pulse bit hits a key already pending and not granted that cycle. At most +1 per cycle.
- Undefined: port and counter absent; merging behaviour unchanged.

Decomposition:
- Package key_evt_pkg:
  - default N_KEYS / FIFO_DEPTH constants.
  - key index constants (KEY_CONFIRM=0, KEY_BACK=1, KEY_UP=2, KEY_DOWN=3, KEY_MODE=4).
  - key_idx_t typedef.
- Sub-module key_evt_fifo: synchronous FIFO with push/pop, count, full/empty, async reset.
- Round-robin search stays inline in key_event_arbiter.

Test Plan:
- Reset, single press: pulse key 2 at cycle 10, evt_ready=1 -> evt_valid=1 with evt_code=2 at cycle 12 for one cycle; pending returns to 0.
- Simultaneous presses: pulses on keys 0, 3 and 4 in one cycle, ready held high -> codes 0, 3, 4 in consecutive cycles; next round starting after 4 with key 0 pending again yields 0.
- Fairness: keys 1 and 2 re-pulsed every cycle, ready=1 -> output alternates 1, 2, 1, 2; neither starves.
- Full / backpressure: ready=0, pulse keys 0..4 -> FIFO holds 0, 1, 2, 3; fifo_full=1; pending=5'b10000. Raise ready -> drains 0, 1, 2, 3, 4 in order with no loss.
- Merge: pulse key 1 three times while ready=0 and FIFO full -> exactly one key-1 event queued later. With KEY_EVT_DROP_CNT_EN, drop_cnt=2.
- Async reset mid-stream: assert rst between edges with 3 events queued -> evt_valid, pending and fifo_full drop immediately. After release, the first event reflects only post-reset pulses.
